// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: NCO phase accumulator feeding a CORDIC rotator; wraps modulo 2*pi
// and, when CORDIC_FOLD_EN is defined, folds the phase into [-pi/2, pi/2].
module cordic_phase_gen #(
    parameter int BITS       = 16,
    parameter int PI_FX      = 51472,
    parameter int HALF_PI_FX = 25736
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [BITS:0] ftw,
    input  logic                 load,
    input  logic signed [BITS:0] load_phase,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [BITS:0] angle,
    output logic                 cos_neg,
    output logic signed [BITS:0] phase
);
    // Handshake: a sample transfers on a cycle with out_valid=1 and out_ready=1; while
    // out_valid=1 and out_ready=0 the whole pipe stalls and every output holds.

`ifdef CORDIC_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    localparam logic signed [BITS+1:0] PI_W      = (BITS+2)'(PI_FX);
    localparam logic signed [BITS+1:0] NEG_PI_W  = (BITS+2)'(-PI_FX);
    localparam logic signed [BITS:0]   PI_N      = (BITS+1)'(PI_FX);
    localparam logic signed [BITS:0]   NEG_PI_N  = (BITS+1)'(-PI_FX);
    localparam logic signed [BITS:0]   TWO_PI_N  = (BITS+1)'(2 * PI_FX);
    localparam logic signed [BITS:0]   HALF_N    = (BITS+1)'(HALF_PI_FX);
    localparam logic signed [BITS:0]   NEG_HALF_N = (BITS+1)'(-HALF_PI_FX);

    logic signed [BITS:0]   acc_q, acc_d;
    logic signed [BITS:0]   p1_q, p1_d;
    logic                   p1_valid_q, p1_valid_d;
    logic signed [BITS:0]   angle_q, angle_d;
    logic signed [BITS:0]   phase_q, phase_d;
    logic                   cos_neg_q, cos_neg_d;
    logic                   out_valid_q, out_valid_d;
    logic                   advance;
    logic signed [BITS+1:0] sum;
    logic signed [BITS:0]   wrapped;
    logic signed [BITS:0]   folded;
    logic                   fold_neg;

    assign advance = out_ready | ~out_valid_q;

    always_comb begin
        sum = {acc_q[BITS], acc_q} + {ftw[BITS], ftw};
        // The wrapped result always fits BITS+1 bits, so the +/-2*pi correction can be
        // done modulo 2^(BITS+1) on the truncated sum.
        wrapped = sum[BITS:0];
        if (sum >= PI_W) begin
            wrapped = sum[BITS:0] - TWO_PI_N;
        end else if (sum < NEG_PI_W) begin
            wrapped = sum[BITS:0] + TWO_PI_N;
        end

        acc_d = acc_q;
        if (load) begin
            acc_d = load_phase;
        end else if (advance && en) begin
            acc_d = wrapped;
        end
    end

    always_comb begin
        folded   = p1_q;
        fold_neg = 1'b0;
        if (FOLD && (p1_q > HALF_N)) begin
            folded   = PI_N - p1_q;
            fold_neg = 1'b1;
        end else if (FOLD && (p1_q < NEG_HALF_N)) begin
            folded   = NEG_PI_N - p1_q;
            fold_neg = 1'b1;
        end
    end

    always_comb begin
        p1_d        = p1_q;
        p1_valid_d  = p1_valid_q;
        angle_d     = angle_q;
        phase_d     = phase_q;
        cos_neg_d   = cos_neg_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            p1_d        = acc_q;
            p1_valid_d  = en;
            angle_d     = folded;
            phase_d     = p1_q;
            cos_neg_d   = fold_neg;
            out_valid_d = p1_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            p1_q        <= '0;
            p1_valid_q  <= 1'b0;
            angle_q     <= '0;
            phase_q     <= '0;
            cos_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            p1_q        <= p1_d;
            p1_valid_q  <= p1_valid_d;
            angle_q     <= angle_d;
            phase_q     <= phase_d;
            cos_neg_q   <= cos_neg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign angle     = angle_q;
    assign cos_neg   = cos_neg_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen; expectations cover both the folded
// (CORDIC_FOLD_EN) and unfolded builds.
module tb_cordic_phase_gen;

`ifdef CORDIC_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, load, out_ready, out_valid, cos_neg;
    logic signed [16:0] ftw, load_phase, angle, phase;
    logic signed [16:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_phase_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ftw        (ftw),
        .load       (load),
        .load_phase (load_phase),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .angle      (angle),
        .cos_neg    (cos_neg),
        .phase      (phase)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected angle/cos_neg: the folded values when folding is built in, else the raw phase.
    function automatic int fa(input int folded_ang, input int ph);
        return FOLD ? folded_ang : ph;
    endfunction

    function automatic int fc(input int folded_cn);
        return FOLD ? folded_cn : 0;
    endfunction

    task automatic check_out(input string tag, input int v, input int ph, input int ang, input int cn);
        check({tag, "_valid"}, out_valid, v);
        check({tag, "_phase"}, phase, ph);
        check({tag, "_angle"}, angle, ang);
        check({tag, "_cosneg"}, cos_neg, cn);
    endtask

    int ld_v[4]  = '{25736, 25737, -25736, -51472};
    int ang_v[4] = '{25736, 25735, -25736, 0};
    int cn_v[4]  = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; ftw = '0; load = 1'b0; load_phase = '0; out_ready = 1'b1;
        #12;
        check_out("por", 0, 0, 0, 0);
        rst = 1'b0; en = 1'b1; ftw = 17'sd1000;
        repeat (4) tick();
        check_out("pre_rst", 1, 2000, 2000, 0);

        // Test 1: asynchronous reset mid-cycle, then restart latency and ramp
        #2 rst = 1'b1;
        #1 check_out("rst_async", 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick();
        check("t1_latency_valid", out_valid, 0);
        for (int k = 0; k < 4; k++) exp_q.push_back(17'(k * 1000));
        while (exp_q.size() > 0) begin
            logic signed [16:0] e;
            e = exp_q.pop_front();
            tick();
            check_out("t1_ramp", 1, e, e, 0);
        end

        // Test 2: positive wrap
        load = 1'b1; load_phase = 17'sd51000; ftw = 17'sd1000;
        tick();
        load = 1'b0;
        tick(); tick();
        check_out("t2_s0", 1, 51000, fa(472, 51000), fc(1));
        tick();
        check_out("t2_s1", 1, -50944, fa(-528, -50944), fc(1));

        // Test 3: negative wrap
        load = 1'b1; load_phase = -17'sd51000; ftw = -17'sd1000;
        tick();
        load = 1'b0;
        tick(); tick();
        check_out("t3_s0", 1, -51000, fa(-472, -51000), fc(1));
        tick();
        check_out("t3_s1", 1, 50944, fa(528, 50944), fc(1));

        // Test 4: fold boundaries
        ftw = '0;
        for (int k = 0; k < 4; k++) begin
            load = 1'b1; load_phase = 17'(ld_v[k]);
            tick();
            load = 1'b0;
            tick(); tick();
            check_out($sformatf("t4_b%0d", k), 1, ld_v[k], fa(ang_v[k], ld_v[k]), fc(cn_v[k]));
        end

        // Test 5: backpressure freezes outputs, then resumes without gap or duplicate
        ftw = 17'sd100; load = 1'b1; load_phase = '0;
        tick();
        load = 1'b0;
        tick(); tick();
        check_out("t5_first", 1, 0, 0, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("t5_stall", 1, 0, 0, 0);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_out("t5_resume", 1, k * 100, k * 100, 0);
        end

        // Test 6: bubbles, then load together with en
        load = 1'b1; load_phase = '0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check_out("t6_b0", 1, 0, 0, 0);
        en = 1'b1;
        tick();
        check("t6_b1_valid", out_valid, 0);
        en = 1'b0;
        tick();
        check_out("t6_b2", 1, 100, 100, 0);
        tick();
        check("t6_b3_valid", out_valid, 0);
        load = 1'b1; load_phase = 17'sd5000; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_out("t6_old_acc", 1, 200, 200, 0);
        tick();
        check_out("t6_loaded", 1, 5000, 5000, 0);
        tick();
        check_out("t6_next", 1, 5100, 5100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
